// File: rtl/sram_pkg.sv
// Shared widths, frame defaults and request/tag records for the SRAM pixel read path.
package sram_pkg;
  localparam int PIXEL_W       = 16;
  localparam int COORD_W       = 11;
  localparam int SRAM_ADDR_W   = 20;
  localparam int H_VISIBLE_DEF = 800;
  localparam int V_VISIBLE_DEF = 600;
  localparam int REQ_W         = 2 * COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } req_t;

  typedef struct packed {
    logic               valid;
    logic               blank;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, blank: 1'b0,
                                x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}};
endpackage

// File: rtl/sram_read_responder_if.sv
// Request/response and SRAM read-port signals of the pixel read responder.
interface sram_read_responder_if;
  import sram_pkg::*;

  logic                   request_active;
  logic [COORD_W-1:0]     request_x;
  logic [COORD_W-1:0]     request_y;
  logic                   request_ready;
  logic [PIXEL_W-1:0]     request_data;
  logic [COORD_W-1:0]     response_x;
  logic [COORD_W-1:0]     response_y;
  logic                   request_overflow;
  logic [7:0]             drop_count;
  logic                   sram_grant;
  logic                   sram_read_en;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [PIXEL_W-1:0]     sram_rdata;

  modport master (
    output request_active, request_x, request_y, sram_grant, sram_rdata,
    input  request_ready, request_data, response_x, response_y,
           request_overflow, drop_count, sram_read_en, sram_addr
  );

  modport slave (
    input  request_active, request_x, request_y, sram_grant, sram_rdata,
    output request_ready, request_data, response_x, response_y,
           request_overflow, drop_count, sram_read_en, sram_addr
  );
endinterface

// File: rtl/sram_req_fifo.sv
// Synchronous request queue with registered head; a push is accepted while full
// when the same cycle pops.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end
endmodule

// File: rtl/sram_read_responder.sv
// Pixel read responder: queues coordinate requests, reads in-frame pixels from SRAM and
// returns tagged responses in request order, with out-of-frame pixels answered as 0x0000.
module sram_read_responder
  import sram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SRAM_LATENCY = 2,
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF
) (
  input logic                  clk,
  input logic                  rst,
  sram_read_responder_if.slave rsp_if
);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_VISIBLE);

  req_t                   wreq_s;
  req_t                   head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   head_oob_s;
  logic                   pop_s;
  logic                   issue_s;
  logic                   push_s;
  logic                   drop_s;
  logic [SRAM_ADDR_W-1:0] y_ext_s;
  logic [SRAM_ADDR_W-1:0] x_ext_s;
  logic [SRAM_ADDR_W-1:0] addr_s;
  tag_t                   tag_d;
  tag_t                   tag_q [SRAM_LATENCY];
  logic                   ready_q;
  logic [PIXEL_W-1:0]     data_q;
  logic [COORD_W-1:0]     resp_x_q;
  logic [COORD_W-1:0]     resp_y_q;
  logic                   overflow_q;
  logic [7:0]             drop_count_q;
  logic [7:0]             drop_count_d;

  assign wreq_s = '{y: rsp_if.request_y, x: rsp_if.request_x};

  sram_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wreq_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Out-of-frame heads drain without a grant; in-frame heads wait for the arbiter
  always_comb begin
    head_oob_s = (head_s.x >= H_LIM) || (head_s.y >= V_LIM);
    pop_s      = 1'b0;
    issue_s    = 1'b0;
    push_s     = 1'b0;
    drop_s     = 1'b0;
    if (rst) begin
      pop_s   = 1'b0;
      issue_s = 1'b0;
    end else begin
      if (!fifo_empty_s) begin
        if (head_oob_s) begin
          pop_s = 1'b1;
        end else if (rsp_if.sram_grant) begin
          pop_s   = 1'b1;
          issue_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end else begin
        pop_s = 1'b0;
      end
      if (rsp_if.request_active) begin
        if (!fifo_full_s || pop_s) push_s = 1'b1;
        else                       drop_s = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // Row-major word address; 800 = 512 + 256 + 32 keeps it to shifts and adds
  always_comb begin
    y_ext_s = SRAM_ADDR_W'(head_s.y);
    x_ext_s = SRAM_ADDR_W'(head_s.x);
    if (H_VISIBLE == 800) begin
      addr_s = (y_ext_s << 4'd9) + (y_ext_s << 4'd8) + (y_ext_s << 4'd5) + x_ext_s;
    end else begin
      addr_s = y_ext_s * SRAM_ADDR_W'(H_VISIBLE) + x_ext_s;
    end
  end

  assign rsp_if.sram_read_en = issue_s;
  assign rsp_if.sram_addr    = issue_s ? addr_s : {SRAM_ADDR_W{1'b0}};

  assign tag_d = '{valid: pop_s, blank: head_oob_s, x: head_s.x, y: head_s.y};

  // Tag shift line aligned with the SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SRAM_LATENCY; i++) tag_q[i] <= TAG_IDLE;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < SRAM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Final stage: capture read data with its tag; payload holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      data_q   <= {PIXEL_W{1'b0}};
      resp_x_q <= {COORD_W{1'b0}};
      resp_y_q <= {COORD_W{1'b0}};
    end else begin
      ready_q <= tag_q[SRAM_LATENCY-1].valid;
      if (tag_q[SRAM_LATENCY-1].valid) begin
        data_q   <= tag_q[SRAM_LATENCY-1].blank ? {PIXEL_W{1'b0}} : rsp_if.sram_rdata;
        resp_x_q <= tag_q[SRAM_LATENCY-1].x;
        resp_y_q <= tag_q[SRAM_LATENCY-1].y;
      end
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_s && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
    else                                    drop_count_d = drop_count_q;
  end

  // Drop reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      overflow_q   <= drop_s;
      drop_count_q <= drop_count_d;
    end
  end

  assign rsp_if.request_ready    = ready_q;
  assign rsp_if.request_data     = data_q;
  assign rsp_if.response_x       = resp_x_q;
  assign rsp_if.response_y       = resp_y_q;
  assign rsp_if.request_overflow = overflow_q;
  assign rsp_if.drop_count       = drop_count_q;
endmodule

// File: tb/tb_sram_read_responder.sv
// Directed bench for sram_read_responder with a fixed-latency SRAM model and response scoreboard.
module tb_sram_read_responder;
  import sram_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_read_responder_if rif ();

  sram_read_responder #(
    .FIFO_DEPTH   (4),
    .SRAM_LATENCY (LAT),
    .H_VISIBLE    (800),
    .V_VISIBLE    (600)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rsp_if (rif.slave)
  );

  function automatic logic [15:0] word_of(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: data appears LAT cycles after the issue cycle
  logic [LAT-1:0] rd_v_q = '0;
  logic [19:0]    rd_a_q [LAT];
  always @(posedge clk) begin
    rd_v_q[0] <= rif.sram_read_en;
    rd_a_q[0] <= rif.sram_addr;
    for (int i = 1; i < LAT; i++) begin
      rd_v_q[i] <= rd_v_q[i-1];
      rd_a_q[i] <= rd_a_q[i-1];
    end
  end
  assign rif.sram_rdata = rd_v_q[LAT-1] ? word_of(rd_a_q[LAT-1]) : 16'hBEEF;

  // Response / overflow recorder
  int          cyc = 0;
  int          obs_n = 0;
  int          ovf_n = 0;
  logic [15:0] obs_d [64];
  logic [10:0] obs_x [64];
  logic [10:0] obs_y [64];
  int          obs_c [64];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rif.request_ready === 1'b1 && obs_n < 64) begin
      obs_d[obs_n] <= rif.request_data;
      obs_x[obs_n] <= rif.response_x;
      obs_y[obs_n] <= rif.response_y;
      obs_c[obs_n] <= cyc;
      obs_n        <= obs_n + 1;
    end
    if (rif.request_overflow === 1'b1) ovf_n <= ovf_n + 1;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_n = 0;
  int          vidx = 0;
  logic [15:0] exp_d [64];
  logic [10:0] exp_x [64];
  logic [10:0] exp_y [64];
  int          t3_x [3] = '{3, 900, 4};
  int          t3_y [3] = '{1, 10, 1};
  int          t3_en [3] = '{1, 0, 1};
  int          t3_a [3] = '{803, 0, 804};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic act, input int x, input int y);
    rif.request_active = act;
    rif.request_x      = 11'(x);
    rif.request_y      = 11'(y);
    @(negedge clk);
  endtask

  task automatic expect_rsp(input int x, input int y);
    exp_x[exp_n] = 11'(x);
    exp_y[exp_n] = 11'(y);
    exp_d[exp_n] = (x >= 800 || y >= 600) ? 16'h0000 : word_of(20'(y * 800 + x));
    exp_n++;
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while (obs_n < exp_n && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_rsp_count"}, 32'(obs_n), 32'(exp_n));
  endtask

  task automatic verify_rsps(input string tag);
    for (int k = vidx; k < exp_n; k++) begin
      if (k < obs_n) begin
        check_eq({tag, "_data"}, 32'(obs_d[k]), 32'(exp_d[k]));
        check_eq({tag, "_x"},    32'(obs_x[k]), 32'(exp_x[k]));
        check_eq({tag, "_y"},    32'(obs_y[k]), 32'(exp_y[k]));
      end
    end
    vidx = exp_n;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"},    32'(rif.request_ready),    32'd0);
    check_eq({tag, "_data"},     32'(rif.request_data),     32'd0);
    check_eq({tag, "_rx"},       32'(rif.response_x),       32'd0);
    check_eq({tag, "_ry"},       32'(rif.response_y),       32'd0);
    check_eq({tag, "_overflow"}, 32'(rif.request_overflow), 32'd0);
    check_eq({tag, "_drops"},    32'(rif.drop_count),       32'd0);
    check_eq({tag, "_rd_en"},    32'(rif.sram_read_en),     32'd0);
    check_eq({tag, "_addr"},     32'(rif.sram_addr),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ovf_base;
    rst = 1'b1;
    rif.request_active = 1'b0;
    rif.request_x = 11'd0;
    rif.request_y = 11'd0;
    rif.sram_grant = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request (5,2): addr 1605, response 4 cycles after the strobe
    rif.sram_grant = 1'b1;
    expect_rsp(5, 2);
    step(1'b1, 5, 2);
    check_eq("t1_rd_en", 32'(rif.sram_read_en), 32'd1);
    check_eq("t1_addr", 32'(rif.sram_addr), 32'h645);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check_eq("t1_ready_early", 32'(rif.request_ready), 32'd0);
    step(1'b0, 0, 0);
    check_eq("t1_ready", 32'(rif.request_ready), 32'd1);
    check_eq("t1_data_now", 32'(rif.request_data), 32'h5C1F);
    check_eq("t1_rx_now", 32'(rif.response_x), 32'd5);
    check_eq("t1_ry_now", 32'(rif.response_y), 32'd2);
    drain("t1");
    verify_rsps("t1");

    // Back-to-back x=0..9: one issue per cycle, consecutive responses
    base = exp_n;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        check_eq("t2_rd_en", 32'(rif.sram_read_en), 32'd1);
        check_eq("t2_addr", 32'(rif.sram_addr), 32'(i - 1));
      end
      if (i < 10) begin
        expect_rsp(i, 0);
        step(1'b1, i, 0);
      end else begin
        step(1'b0, 0, 0);
      end
    end
    drain("t2");
    for (int k = base + 1; k < base + 10 && k < obs_n; k++)
      check_eq("t2_gap", 32'(obs_c[k] - obs_c[k-1]), 32'd1);
    verify_rsps("t2");

    // Out-of-frame request between two in-frame ones
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        check_eq("t3_rd_en", 32'(rif.sram_read_en), 32'(t3_en[i-1]));
        if (t3_en[i-1] != 0) check_eq("t3_addr", 32'(rif.sram_addr), 32'(t3_a[i-1]));
      end
      if (i < 3) begin
        expect_rsp(t3_x[i], t3_y[i]);
        step(1'b1, t3_x[i], t3_y[i]);
      end else begin
        step(1'b0, 0, 0);
      end
    end
    drain("t3");
    verify_rsps("t3");
    check_eq("t3_hold_ready", 32'(rif.request_ready), 32'd0);
    check_eq("t3_hold_data", 32'(rif.request_data), 32'(word_of(20'd804)));
    check_eq("t3_hold_rx", 32'(rif.response_x), 32'd4);

    // Stalled queue: 6 strobes, 4 accepted, 2 dropped
    rif.sram_grant = 1'b0;
    ovf_base = ovf_n;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) check_eq("t4_no_issue", 32'(rif.sram_read_en), 32'd0);
      if (i < 6) begin
        if (i < 4) expect_rsp(10 + i, 3);
        step(1'b1, 10 + i, 3);
      end else begin
        step(1'b0, 0, 0);
      end
    end
    check_eq("t4_ovf_pulses", 32'(ovf_n - ovf_base), 32'd2);
    check_eq("t4_drops", 32'(rif.drop_count), 32'd2);
    rif.sram_grant = 1'b1;
    drain("t4");
    verify_rsps("t4");

    // Drop counter saturation
    rif.sram_grant = 1'b0;
    ovf_base = ovf_n;
    for (int i = 0; i < 256; i++) begin
      if (i < 4) expect_rsp(1, 1);
      step(1'b1, 1, 1);
    end
    step(1'b0, 0, 0);
    check_eq("t5_drops_254", 32'(rif.drop_count), 32'd254);
    for (int i = 0; i < 44; i++) step(1'b1, 1, 1);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check_eq("t5_drops_sat", 32'(rif.drop_count), 32'd255);
    check_eq("t5_ovf_pulses", 32'(ovf_n - ovf_base), 32'd296);
    rif.sram_grant = 1'b1;
    drain("t5");
    verify_rsps("t5");

    // Reset with reads in flight: only the response already leaving survives
    expect_rsp(20, 5);
    step(1'b1, 20, 5);
    step(1'b1, 21, 5);
    step(1'b1, 22, 5);
    step(1'b0, 0, 0);
    rst = 1'b1;
    step(1'b1, 7, 7);
    check_outputs_zero("t6_in_reset");
    step(1'b1, 7, 7);
    rst = 1'b0;
    base = obs_n;
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0);
    check_eq("t6_silent", 32'(obs_n - base), 32'd0);
    check_eq("t6_total", 32'(obs_n), 32'(exp_n));
    verify_rsps("t6");

    // Post-reset request answered at nominal latency
    expect_rsp(8, 0);
    step(1'b1, 8, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check_eq("t7_ready_early", 32'(rif.request_ready), 32'd0);
    step(1'b0, 0, 0);
    check_eq("t7_ready", 32'(rif.request_ready), 32'd1);
    drain("t7");
    verify_rsps("t7");

    check_eq("final_rsp_count", 32'(obs_n), 32'(exp_n));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_read_responder.md
SRAM_READ_RESPONDER -- requirements
Module: sram_read_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning pending-request queue depth (power of two, 2..16).
REQ-002 Parameter SRAM_LATENCY, default 2, meaning cycles from read issue to sram_rdata valid.
REQ-003 Parameter H_VISIBLE, default 800, meaning stored frame width in pixels.
REQ-004 Parameter V_VISIBLE, default 600, meaning stored frame height in lines.
REQ-005 clk  in  1  single clock; all logic on its rising edge; no other clocks.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 request_active  in  1  one-cycle read request strobe.
REQ-008 request_x  in  11  requested pixel column.
REQ-009 request_y  in  11  requested pixel line.
REQ-010 request_ready  out  1  one-cycle response strobe.
REQ-011 request_data  out  16  RGB565 pixel, valid with request_ready.
REQ-012 response_x, response_y  out  11 each  coordinate tag of the current response.
REQ-013 request_overflow  out  1  one-cycle pulse when a request is dropped.
REQ-014 drop_count  out  8  saturating count of dropped requests.
REQ-015 sram_grant  in  1  arbiter permits a read issue this cycle.
REQ-016 sram_read_en  out  1  read issue strobe to the SRAM port.
REQ-017 sram_addr  out  20  word address for the read issue.
REQ-018 sram_rdata  in  16  SRAM read data, valid SRAM_LATENCY cycles after issue.

Function
REQ-019 Request SHALL be pushed into the FIFO on request_active when not full, or when full and a pop occurs in the same cycle.
REQ-020 request_active while full with no pop SHALL drop the request, pulse request_overflow next cycle, increment drop_count saturating at 255.
REQ-021 Head entry in-bounds (x < H_VISIBLE and y < V_VISIBLE) SHALL issue only when sram_grant=1: sram_read_en=1, sram_addr = y*H_VISIBLE + x (shift-add, 20-bit), entry popped.
REQ-022 Head entry out-of-bounds SHALL pop regardless of sram_grant with sram_read_en=0, marked blank.
REQ-023 Every pop SHALL enter a tag pipeline of SRAM_LATENCY+1 stages carrying valid, blank, x, y.
REQ-024 For a pop at cycle T, request_ready SHALL be 1 at T+SRAM_LATENCY+1, registered, with request_data = sram_rdata sampled at T+SRAM_LATENCY (0x0000 if blank), and response_x/y = the popped tag.
REQ-025 Minimum latency request_active -> request_ready SHALL be SRAM_LATENCY+2 cycles (4 at default).
REQ-026 Responses SHALL be returned strictly in request order, blanks included; at most one pop per cycle.
REQ-027 sram_grant=0 with in-bounds head SHALL stall the queue; pushes continue until full.
REQ-028 A push into an empty FIFO SHALL not pop in the same cycle (registered head).
REQ-029 request_data, response_x, response_y SHALL hold their last value when request_ready=0.

Reset
REQ-030 rst=1 SHALL clear FIFO, tag pipeline, drop_count; request_ready, request_overflow, sram_read_en = 0; sram_addr, request_data, response_x, response_y = 0.
REQ-031 Requests queued or in flight at reset SHALL produce no response; request_active during rst SHALL be ignored.

Structure
REQ-032 Shared package sram_pkg SHALL hold PIXEL_W=16, COORD_W=11, SRAM_ADDR_W=20 and the default H_VISIBLE/V_VISIBLE.
REQ-033 Queue SHALL be a sub-module sram_req_fifo (synchronous, 22-bit entries, full/empty flags, same-cycle push/pop when full).
REQ-034 Address multiply SHALL be shift-add for H_VISIBLE=800 (y<<9 + y<<8 + y<<5 + x); no DSP inference required.

Verification
REQ-035 Single request x=5,y=2, grant=1 -> sram_addr=0x00645 (1605) one cycle later; request_ready 4 cycles after strobe, data = SRAM model word, tag (5,2).
REQ-036 Back-to-back requests x=0..9, y=0, grant=1 -> 10 responses in order, consecutive cycles, addresses 0..9.
REQ-037 Request x=900,y=10 between two in-bounds requests -> no sram_read_en for it, response data 0x0000, tag (900,10), order preserved.
REQ-038 grant=0 for 10 cycles with 6 strobes -> 4 queued, 2 overflow pulses, drop_count=2; on grant=1 four responses in order.
REQ-039 300 strobes with grant=0 -> drop_count saturates at 255.
REQ-040 rst asserted 2 cycles after 3 issued reads -> no request_ready afterwards, all outputs 0, next request answered at nominal latency.
